frogger_round_ctrl: RTL and testbench

//  Game-round sequencer for Frogger. Owns lives, win/lose/death state, active-frog selection and
//  key-to-move conversion. Sits between the keycode PIO and the frog / car_row / lilypad_row

---
 rtl/frogger_round_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_frogger_round_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frogger_round_ctrl.sv
// rtl/frogger_round_ctrl.sv - Frogger round sequencer: lives, win/lose/death, frog select, key moves
module frogger_round_ctrl #(
   parameter int LIVES_INIT   = 3,
   parameter int DEATH_FRAMES = 60,
   parameter int REPEAT_FR    = 8
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        frame_clk,
   input  logic        start,
   input  logic [15:0] keycode,
   input  logic [2:0]  dead_in,
   input  logic [2:0]  home_in,
   output logic [2:0]  frog_sel,
   output logic        mv_up,
   output logic        mv_down,
   output logic        mv_left,
   output logic        mv_right,
   output logic [2:0]  respawn,
   output logic        freeze,
   output logic [1:0]  lives,
   output logic        win_game,
   output logic        lose_game,
   output logic [2:0]  state
);

   localparam int DCNT_W = $clog2(DEATH_FRAMES + 1);
   localparam int RCNT_W = $clog2(REPEAT_FR + 1);
   localparam logic [1:0]        LIVES_RST  = 2'(LIVES_INIT);
   localparam logic [DCNT_W-1:0] DEATH_LOAD = DCNT_W'(DEATH_FRAMES - 1);
   localparam logic [RCNT_W-1:0] REP_LOAD   = RCNT_W'(REPEAT_FR - 1);

   localparam logic [15:0] K_UP    = 16'h0052;
   localparam logic [15:0] K_DOWN  = 16'h0051;
   localparam logic [15:0] K_LEFT  = 16'h0050;
   localparam logic [15:0] K_RIGHT = 16'h004F;
   localparam logic [15:0] K_F1    = 16'h0059;
   localparam logic [15:0] K_F2    = 16'h005A;
   localparam logic [15:0] K_F3    = 16'h005B;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PLAY  = 3'd1,
      S_DYING = 3'd2,
      S_WIN   = 3'd3,
      S_LOSE  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        sync_q, sync_d;
   logic [15:0]       key_prev_q, key_prev_d;
   logic [RCNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic [DCNT_W-1:0] dcnt_q, dcnt_d;
   logic [2:0]        home_q, home_d;
   logic [2:0]        dead_q, dead_d;
   logic [2:0]        frog_sel_q, frog_sel_d;
   logic [2:0]        respawn_q, respawn_d;
   logic [1:0]        lives_q, lives_d;
   logic              freeze_q, freeze_d;
   logic              win_q, win_d;
   logic              lose_q, lose_d;
   logic [3:0]        mv_q, mv_d;

   logic frame_tick;
   logic is_arrow;
   logic mv_fire;

   assign frame_tick = sync_q[1] & ~sync_q[2];
   assign is_arrow   = (keycode == K_UP) || (keycode == K_DOWN) ||
                       (keycode == K_LEFT) || (keycode == K_RIGHT);

   // Key repeat: a new arrow code zeroes the counter so the next tick fires; later fires every REPEAT_FR ticks
   always_comb begin
      sync_d     = {sync_q[1:0], frame_clk};
      key_prev_d = keycode;
      rep_cnt_d  = rep_cnt_q;
      mv_fire    = 1'b0;
      if (keycode != key_prev_q) begin
         rep_cnt_d = '0;
      end
      if (frame_tick && is_arrow) begin
         if (rep_cnt_d == '0) begin
            mv_fire   = 1'b1;
            rep_cnt_d = REP_LOAD;
         end else begin
            rep_cnt_d = rep_cnt_d - RCNT_W'(1);
         end
      end
      mv_d = 4'b0000;
      if (mv_fire && (state_q == S_PLAY)) begin
         mv_d = {keycode == K_RIGHT, keycode == K_LEFT, keycode == K_DOWN, keycode == K_UP};
      end
   end

   // Round FSM, lives, home mask and frog selection; start overrides every state
   always_comb begin
      state_d    = state_q;
      lives_d    = lives_q;
      home_d     = home_q;
      dead_d     = dead_q;
      dcnt_d     = dcnt_q;
      respawn_d  = 3'b000;
      frog_sel_d = frog_sel_q;
      if (start) begin
         state_d   = S_PLAY;
         respawn_d = 3'b111;
         lives_d   = LIVES_RST;
         home_d    = 3'b000;
         dead_d    = 3'b000;
         dcnt_d    = '0;
      end else if (frame_tick) begin
         case (state_q)
            S_PLAY: begin
               if (|dead_in) begin
                  dead_d  = dead_in;
                  lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                  if (lives_q <= 2'd1) begin
                     state_d = S_LOSE;
                  end else begin
                     dcnt_d  = DEATH_LOAD;
                     state_d = S_DYING;
                  end
               end else begin
                  home_d = home_q | home_in;
                  if (home_d == 3'b111) begin
                     state_d = S_WIN;
                  end
               end
            end
            S_DYING: begin
               if (dcnt_q == '0) begin
                  respawn_d = dead_q;
                  dead_d    = 3'b000;
                  state_d   = S_PLAY;
               end else begin
                  dcnt_d = dcnt_q - DCNT_W'(1);
               end
            end
            default: ;
         endcase
      end
      // Active frog just got home: hand control to the lowest frog still out
      if (((frog_sel_q & home_d) != 3'b000) && (home_d != 3'b111)) begin
         if (!home_d[0]) begin
            frog_sel_d = 3'b001;
         end else if (!home_d[1]) begin
            frog_sel_d = 3'b010;
         end else begin
            frog_sel_d = 3'b100;
         end
      end else if ((keycode == K_F1) && !home_d[0]) begin
         frog_sel_d = 3'b001;
      end else if ((keycode == K_F2) && !home_d[1]) begin
         frog_sel_d = 3'b010;
      end else if ((keycode == K_F3) && !home_d[2]) begin
         frog_sel_d = 3'b100;
      end
      freeze_d = (state_d != S_PLAY);
      win_d    = (state_d == S_WIN);
      lose_d   = (state_d == S_LOSE);
   end

   // State and registered outputs
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= S_IDLE;
         sync_q     <= 3'b000;
         key_prev_q <= 16'h0000;
         rep_cnt_q  <= '0;
         dcnt_q     <= '0;
         home_q     <= 3'b000;
         dead_q     <= 3'b000;
         frog_sel_q <= 3'b001;
         respawn_q  <= 3'b000;
         lives_q    <= LIVES_RST;
         freeze_q   <= 1'b1;
         win_q      <= 1'b0;
         lose_q     <= 1'b0;
         mv_q       <= 4'b0000;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         key_prev_q <= key_prev_d;
         rep_cnt_q  <= rep_cnt_d;
         dcnt_q     <= dcnt_d;
         home_q     <= home_d;
         dead_q     <= dead_d;
         frog_sel_q <= frog_sel_d;
         respawn_q  <= respawn_d;
         lives_q    <= lives_d;
         freeze_q   <= freeze_d;
         win_q      <= win_d;
         lose_q     <= lose_d;
         mv_q       <= mv_d;
      end
   end

   assign state     = state_q;
   assign frog_sel  = frog_sel_q;
   assign respawn   = respawn_q;
   assign lives     = lives_q;
   assign freeze    = freeze_q;
   assign win_game  = win_q;
   assign lose_game = lose_q;
   assign mv_up     = mv_q[0];
   assign mv_down   = mv_q[1];
   assign mv_left   = mv_q[2];
   assign mv_right  = mv_q[3];

endmodule

// File: tb/tb_frogger_round_ctrl.sv
// tb/tb_frogger_round_ctrl.sv - Self-checking bench for frogger_round_ctrl
module tb_frogger_round_ctrl;

   localparam int REPEAT = 8;
   localparam int DEATH  = 60;

   logic        Clk = 1'b0;
   logic        Reset_n, frame_clk, start;
   logic [15:0] keycode;
   logic [2:0]  dead_in, home_in;
   logic [2:0]  frog_sel, respawn, state;
   logic        mv_up, mv_down, mv_left, mv_right, freeze, win_game, lose_game;
   logic [1:0]  lives;

   int checks = 0;
   int errors = 0;

   int         mv_hi[4];
   int         mv_rise[4];
   logic [3:0] mv_prev = 4'b0;
   int         multi_hi = 0;
   int         resp_cnt = 0;
   logic [2:0] resp_last = 3'b0;

   frogger_round_ctrl dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .start(start),
      .keycode(keycode), .dead_in(dead_in), .home_in(home_in),
      .frog_sel(frog_sel), .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left),
      .mv_right(mv_right), .respawn(respawn), .freeze(freeze), .lives(lives),
      .win_game(win_game), .lose_game(lose_game), .state(state)
   );

   always #10 Clk = ~Clk;

   // Pulse monitor sampled on the inactive edge
   always @(negedge Clk) begin
      logic [3:0] v;
      v = {mv_right, mv_left, mv_down, mv_up};
      for (int i = 0; i < 4; i++) begin
         if (v[i]) mv_hi[i]++;
         if (v[i] && !mv_prev[i]) mv_rise[i]++;
      end
      if ((int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3])) > 1) multi_hi++;
      mv_prev = v;
      if (respawn != 3'b000) begin
         resp_cnt++;
         resp_last = respawn;
      end
   end

   task automatic frame();
      @(negedge Clk) frame_clk = 1'b1;
      repeat (5) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (5) @(negedge Clk);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic restart();
      @(negedge Clk) start = 1'b1;
      @(negedge Clk) start = 1'b0;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0; frame_clk = 1'b0; start = 1'b0;
      keycode = 16'h0; dead_in = 3'b0; home_in = 3'b0;
      for (int i = 0; i < 4; i++) begin mv_hi[i] = 0; mv_rise[i] = 0; end
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      checks++;
      if ({state, frog_sel, respawn, freeze, lives, win_game, lose_game} !==
          {3'd0, 3'b001, 3'b000, 1'b1, 2'd3, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs state=%0d sel=%b resp=%b frz=%b lives=%0d win=%b lose=%b",
                  state, frog_sel, respawn, freeze, lives, win_game, lose_game);
      end
      checks++;
      if ({mv_up, mv_down, mv_left, mv_right} !== 4'b0000) begin
         errors++; $display("FAIL reset_moves got %b exp 0000", {mv_up, mv_down, mv_left, mv_right});
      end
   endtask

   task automatic test_start();
      @(negedge Clk) start = 1'b1;
      @(negedge Clk) start = 1'b0;
      checks++;
      if ({respawn, state, lives, freeze} !== {3'b111, 3'd1, 2'd3, 1'b0}) begin
         errors++;
         $display("FAIL start_play resp=%b state=%0d lives=%0d frz=%b exp 111/1/3/0",
                  respawn, state, lives, freeze);
      end
      @(negedge Clk);
      checks++;
      if (respawn !== 3'b000) begin errors++; $display("FAIL start_respawn_width got %b exp 000", respawn); end
   endtask

   task automatic test_death_respawn();
      int rc;
      dead_in = 3'b010; frame(); dead_in = 3'b000;
      checks++;
      if ({lives, state, freeze} !== {2'd2, 3'd2, 1'b1}) begin
         errors++; $display("FAIL death_enter lives=%0d state=%0d frz=%b exp 2/2/1", lives, state, freeze);
      end
      rc = resp_cnt;
      frames(DEATH - 1);
      checks++;
      if (state !== 3'd2 || resp_cnt != rc) begin
         errors++; $display("FAIL dying_hold state=%0d respawns=%0d exp 2/0", state, resp_cnt - rc);
      end
      frame();
      checks++;
      if (resp_cnt - rc != 1 || resp_last !== 3'b010 || state !== 3'd1 || freeze !== 1'b0) begin
         errors++;
         $display("FAIL dying_respawn pulses=%0d resp=%b state=%0d frz=%b exp 1/010/1/0",
                  resp_cnt - rc, resp_last, state, freeze);
      end
   endtask

   task automatic test_lose();
      int h;
      dead_in = 3'b100; frame(); dead_in = 3'b000;
      frames(DEATH);
      dead_in = 3'b001; frame(); dead_in = 3'b000;
      checks++;
      if ({lives, lose_game, win_game, freeze, state} !== {2'd0, 1'b1, 1'b0, 1'b1, 3'd4}) begin
         errors++;
         $display("FAIL lose lives=%0d lose=%b win=%b frz=%b state=%0d exp 0/1/0/1/4",
                  lives, lose_game, win_game, freeze, state);
      end
      h = mv_hi[0] + mv_hi[1] + mv_hi[2] + mv_hi[3];
      keycode = 16'h0052; frames(10);
      keycode = 16'h004F; frames(3); keycode = 16'h0;
      dead_in = 3'b111; frame(); dead_in = 3'b000;
      checks++;
      if (mv_hi[0] + mv_hi[1] + mv_hi[2] + mv_hi[3] != h || lives !== 2'd0) begin
         errors++; $display("FAIL lose_frozen moves=%0d lives=%0d exp 0/0",
                            mv_hi[0] + mv_hi[1] + mv_hi[2] + mv_hi[3] - h, lives);
      end
   endtask

   task automatic test_repeat();
      int h, r;
      restart();
      h = mv_hi[0]; r = mv_rise[0];
      keycode = 16'h0052; frames(20); keycode = 16'h0;
      frames(1);
      checks++;
      if (mv_hi[0] - h != 3 || mv_rise[0] - r != 3) begin
         errors++; $display("FAIL repeat_up high_cycles=%0d pulses=%0d exp 3/3", mv_hi[0] - h, mv_rise[0] - r);
      end
   endtask

   // Reference: frames since the key appeared p=1,2,..; a move fires when (p-1) is a multiple of REPEAT
   task automatic test_moves_random();
      logic [15:0] codes[6];
      logic [15:0] prev, code;
      int exp_cnt[4], h0[4], r0[4];
      int p, len, d, m0;
      codes[0] = 16'h0052; codes[1] = 16'h0051; codes[2] = 16'h0050;
      codes[3] = 16'h004F; codes[4] = 16'h0004; codes[5] = 16'h0000;
      for (int i = 0; i < 4; i++) begin exp_cnt[i] = 0; h0[i] = mv_hi[i]; r0[i] = mv_rise[i]; end
      m0 = multi_hi;
      prev = keycode; p = 0;
      for (int s = 0; s < 14; s++) begin
         code = codes[$urandom_range(0, 5)];
         len = $urandom_range(1, 12);
         if (code != prev) p = 0;
         prev = code;
         keycode = code;
         d = -1;
         for (int i = 0; i < 4; i++) if (code == codes[i]) d = i;
         for (int f = 0; f < len; f++) begin
            frame();
            p++;
            if (d >= 0 && ((p - 1) % REPEAT) == 0) exp_cnt[d]++;
         end
      end
      keycode = 16'h0; frame();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mv_hi[i] - h0[i] != exp_cnt[i] || mv_rise[i] - r0[i] != exp_cnt[i]) begin
            errors++;
            $display("FAIL random_moves dir%0d high_cycles=%0d pulses=%0d exp %0d",
                     i, mv_hi[i] - h0[i], mv_rise[i] - r0[i], exp_cnt[i]);
         end
      end
      checks++;
      if (multi_hi != m0) begin errors++; $display("FAIL one_hot_moves overlaps=%0d exp 0", multi_hi - m0); end
   endtask

   task automatic test_home_win();
      restart();
      home_in = 3'b001; frame(); home_in = 3'b000;
      checks++;
      if (frog_sel !== 3'b010) begin errors++; $display("FAIL home1_sel got %b exp 010", frog_sel); end
      @(negedge Clk) keycode = 16'h0059;
      @(negedge Clk);
      @(negedge Clk) keycode = 16'h0;
      checks++;
      if (frog_sel !== 3'b010) begin errors++; $display("FAIL sel_home_ignored got %b exp 010", frog_sel); end
      home_in = 3'b010; frame(); home_in = 3'b000;
      checks++;
      if (frog_sel !== 3'b100) begin errors++; $display("FAIL home2_sel got %b exp 100", frog_sel); end
      home_in = 3'b100; frame(); home_in = 3'b000;
      checks++;
      if ({win_game, lose_game, state, freeze} !== {1'b1, 1'b0, 3'd3, 1'b1}) begin
         errors++; $display("FAIL win win=%b lose=%b state=%0d frz=%b exp 1/0/3/1",
                            win_game, lose_game, state, freeze);
      end
   endtask

   task automatic test_home_death();
      restart();
      home_in = 3'b001; frame();
      home_in = 3'b010; frame();
      home_in = 3'b100; dead_in = 3'b001; frame();
      home_in = 3'b000; dead_in = 3'b000;
      checks++;
      if ({state, win_game, lives, frog_sel} !== {3'd2, 1'b0, 2'd2, 3'b100}) begin
         errors++; $display("FAIL death_beats_home state=%0d win=%b lives=%0d sel=%b exp 2/0/2/100",
                            state, win_game, lives, frog_sel);
      end
   endtask

   task automatic test_select_reset();
      restart();
      @(negedge Clk) keycode = 16'h005A;
      @(negedge Clk) keycode = 16'h0;
      checks++;
      if (frog_sel !== 3'b010) begin errors++; $display("FAIL select_f2 got %b exp 010", frog_sel); end
      repeat (3) @(negedge Clk);
      checks++;
      if (frog_sel !== 3'b010) begin errors++; $display("FAIL select_sticky got %b exp 010", frog_sel); end
      dead_in = 3'b010; frame(); dead_in = 3'b000;
      frames(5);
      #2 Reset_n = 1'b0;
      #1;
      checks++;
      if ({state, lives, freeze, frog_sel, win_game, lose_game} !==
          {3'd0, 2'd3, 1'b1, 3'b001, 1'b0, 1'b0}) begin
         errors++; $display("FAIL async_reset state=%0d lives=%0d frz=%b sel=%b exp 0/3/1/001",
                            state, lives, freeze, frog_sel);
      end
      @(negedge Clk) Reset_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_start();
      test_death_respawn();
      test_lose();
      test_repeat();
      test_moves_random();
      test_home_win();
      test_home_death();
      test_select_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
